// File: rtl/plot_write_scheduler.sv
// Round-robin arbiter feeding N sample sources into the single plot_graph write port.
// Writes whose column is being scanned, or is next, are deferred until they are clear or time out.
module plot_write_scheduler #(
  parameter int N_SRC        = 2,
  parameter int COORD_W      = 2,
  parameter int AVOID_ACTIVE = 1,
  parameter int MAX_DEFER    = 15
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [N_SRC-1:0]           req_i,
  input  logic [N_SRC*COORD_W-1:0]   coord_i,
  input  logic [N_SRC-1:0]           data_i,
  output logic [N_SRC-1:0]           gnt_o,
  input  logic [COORD_W-1:0]         current_column_i,
  output logic                       newdata_o,
  output logic [COORD_W-1:0]         plotcoord_o,
  output logic                       plotdata_o,
  output logic                       busy_o,
  output logic [7:0]                 force_cnt_o
);

  localparam int PTR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int WAIT_W = $clog2(MAX_DEFER + 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_ISSUE} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [COORD_W-1:0]  hold_coord_q, hold_coord_d;
  logic                hold_data_q, hold_data_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                newdata_q, newdata_d;
  logic [COORD_W-1:0]  plotcoord_q, plotcoord_d;
  logic                plotdata_q, plotdata_d;
  logic [7:0]          force_cnt_q, force_cnt_d;

  logic                win_valid;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    win_ptr_next;
  logic [COORD_W-1:0]  win_coord;
  logic                grant_take;
  logic [COORD_W-1:0]  next_col;
  logic                conflict;
  logic                defer_done;
  int                  k;

  // Scan from the farthest candidate to the nearest so the one closest to ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    win_valid = 1'b0;
    win_idx   = '0;
    k         = 0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      k = int'(ptr_q) + i;
      if (k >= N_SRC) k = k - N_SRC;
      if (req_i[k]) begin
        win_valid = 1'b1;
        win_idx   = PTR_W'(k);
      end
    end
  end

  assign win_ptr_next = (win_idx == PTR_W'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
  assign win_coord    = coord_i[win_idx*COORD_W +: COORD_W];
  assign grant_take   = !rst_i && win_valid && (state_q == S_IDLE || state_q == S_ISSUE);
  assign gnt_o        = grant_take ? (N_SRC'(1) << win_idx) : '0;

  assign next_col   = current_column_i + COORD_W'(1);
  assign conflict   = (AVOID_ACTIVE != 0) &&
                      (hold_coord_q == current_column_i || hold_coord_q == next_col);
  assign defer_done = (wait_cnt_q == WAIT_W'(MAX_DEFER));

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    hold_coord_d = hold_coord_q;
    hold_data_d  = hold_data_q;
    wait_cnt_d   = wait_cnt_q;
    newdata_d    = 1'b0;
    plotcoord_d  = plotcoord_q;
    plotdata_d   = plotdata_q;
    force_cnt_d  = force_cnt_q;

    case (state_q)
      S_IDLE:  ;
      S_HOLD: begin
        if (conflict && !defer_done) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
          state_d     = S_ISSUE;
          newdata_d   = 1'b1;
          plotcoord_d = hold_coord_q;
          plotdata_d  = hold_data_q;
          if (conflict && force_cnt_q != 8'hFF) force_cnt_d = force_cnt_q + 8'd1;
        end
      end
      S_ISSUE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Grants only happen in IDLE or ISSUE, so this never collides with the HOLD branch.
    if (grant_take) begin
      state_d      = S_HOLD;
      ptr_d        = win_ptr_next;
      hold_coord_d = win_coord;
      hold_data_d  = data_i[win_idx];
      wait_cnt_d   = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      hold_coord_q <= '0;
      hold_data_q  <= 1'b0;
      wait_cnt_q   <= '0;
      newdata_q    <= 1'b0;
      plotcoord_q  <= '0;
      plotdata_q   <= 1'b0;
      force_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      hold_coord_q <= hold_coord_d;
      hold_data_q  <= hold_data_d;
      wait_cnt_q   <= wait_cnt_d;
      newdata_q    <= newdata_d;
      plotcoord_q  <= plotcoord_d;
      plotdata_q   <= plotdata_d;
      force_cnt_q  <= force_cnt_d;
    end
  end

  assign newdata_o   = newdata_q;
  assign plotcoord_o = plotcoord_q;
  assign plotdata_o  = plotdata_q;
  assign busy_o      = (state_q != S_IDLE);
  assign force_cnt_o = force_cnt_q;

endmodule

// File: tb/tb_plot_write_scheduler.sv
// Bench for plot_write_scheduler: a cycle table for reset, single and round-robin writes,
// then hand sequences for deferral, timeout forcing, the never-defer variant and mid-hold reset.
module tb_plot_write_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] crd;
  logic [1:0] dat;
  logic [1:0] cur;

  logic [1:0] gnt, gnt_na;
  logic       nd, nd_na;
  logic [1:0] pc, pc_na;
  logic       pd, pd_na;
  logic       bsy, bsy_na;
  logic [7:0] fc, fc_na;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  plot_write_scheduler #(.N_SRC(2), .COORD_W(2), .AVOID_ACTIVE(1), .MAX_DEFER(15)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .coord_i(crd), .data_i(dat), .gnt_o(gnt),
    .current_column_i(cur), .newdata_o(nd), .plotcoord_o(pc), .plotdata_o(pd),
    .busy_o(bsy), .force_cnt_o(fc)
  );

  plot_write_scheduler #(.N_SRC(2), .COORD_W(2), .AVOID_ACTIVE(0), .MAX_DEFER(15)) dut_na (
    .clk_i(clk), .rst_i(rst), .req_i(req), .coord_i(crd), .data_i(dat), .gnt_o(gnt_na),
    .current_column_i(cur), .newdata_o(nd_na), .plotcoord_o(pc_na), .plotdata_o(pd_na),
    .busy_o(bsy_na), .force_cnt_o(fc_na)
  );

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [3:0] crd;
    logic [1:0] dat;
    logic [1:0] cur;
    logic [1:0] g;
    logic       nd;
    logic [1:0] pc;
    logic       pd;
    logic       bsy;
    logic [7:0] fc;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and let combinational outputs settle.
  task automatic step(input logic r, input logic [1:0] rq, input logic [3:0] c,
                      input logic [1:0] d, input logic [1:0] cc);
    @(negedge clk);
    rst = r; req = rq; crd = c; dat = d; cur = cc;
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 2'b11; crd = '0; dat = '0; cur = '0;

    // rst,req,crd,dat,cur | gnt,newdata,plotcoord,plotdata,busy,force_cnt
    vecs[0]  = '{1'b1, 2'b11, 4'h0, 2'b00, 2'd0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 2'b11, 4'h0, 2'b00, 2'd0, 2'b00, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 2'b01, 4'h1, 2'b01, 2'd3, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 2'b00, 4'h1, 2'b01, 2'd3, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 8'd0};
    vecs[4]  = '{1'b0, 2'b00, 4'h1, 2'b01, 2'd3, 2'b00, 1'b1, 2'd1, 1'b1, 1'b1, 8'd0};
    vecs[5]  = '{1'b0, 2'b00, 4'h1, 2'b01, 2'd3, 2'b00, 1'b0, 2'd1, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 2'b00, 4'h1, 2'b01, 2'd3, 2'b00, 1'b0, 2'd1, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 2'b11, 4'h4, 2'b10, 2'd2, 2'b01, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 2'b10, 4'h4, 2'b10, 2'd2, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 8'd0};
    vecs[9]  = '{1'b0, 2'b10, 4'h4, 2'b10, 2'd2, 2'b10, 1'b1, 2'd0, 1'b0, 1'b1, 8'd0};
    vecs[10] = '{1'b0, 2'b00, 4'h4, 2'b10, 2'd2, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 8'd0};
    vecs[11] = '{1'b0, 2'b11, 4'h4, 2'b10, 2'd2, 2'b01, 1'b1, 2'd1, 1'b1, 1'b1, 8'd0};
    vecs[12] = '{1'b0, 2'b10, 4'h4, 2'b10, 2'd2, 2'b00, 1'b0, 2'd1, 1'b1, 1'b1, 8'd0};
    vecs[13] = '{1'b0, 2'b10, 4'h4, 2'b10, 2'd2, 2'b10, 1'b1, 2'd0, 1'b0, 1'b1, 8'd0};
    vecs[14] = '{1'b0, 2'b00, 4'h4, 2'b10, 2'd2, 2'b00, 1'b0, 2'd0, 1'b0, 1'b1, 8'd0};
    vecs[15] = '{1'b0, 2'b00, 4'h4, 2'b10, 2'd2, 2'b00, 1'b1, 2'd1, 1'b1, 1'b1, 8'd0};
    vecs[16] = '{1'b0, 2'b00, 4'h4, 2'b10, 2'd2, 2'b00, 1'b0, 2'd1, 1'b1, 1'b0, 8'd0};

    // Reset, single write, round-robin pair and repeat.
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].crd, vecs[i].dat, vecs[i].cur);
      check($sformatf("vec%0d gnt,nd,pc,pd,busy,fc", i),
            {17'd0, gnt, nd, pc, pd, bsy, fc},
            {17'd0, vecs[i].g, vecs[i].nd, vecs[i].pc, vecs[i].pd, vecs[i].bsy, vecs[i].fc});
    end

    // Deferral: coord 2 against scan column 2 for five HOLD cycles, then column 0 clears it.
    step(1'b0, 2'b10, 4'h8, 2'b10, 2'd2);
    check("defer_gnt", gnt, 2'b10);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'b00, 4'h8, 2'b10, 2'd2);
      check($sformatf("defer_hold%0d nd,busy", i), {nd, bsy}, 2'b01);
    end
    step(1'b0, 2'b00, 4'h8, 2'b10, 2'd0);
    check("defer_clear nd", nd, 1'b0);
    step(1'b0, 2'b00, 4'h8, 2'b10, 2'd0);
    check("defer_write nd,pc,pd", {nd, pc, pd}, {1'b1, 2'd2, 1'b1});
    check("defer_force_cnt", fc, 8'd0);

    // Timeout: coord 3 against column 3 forever; the avoiding copy forces at T+17,
    // the non-avoiding copy writes at T+2.
    step(1'b1, 2'b00, 4'h3, 2'b01, 2'd3);
    check("t5_rst_gnt", gnt, 2'b00);
    step(1'b0, 2'b01, 4'h3, 2'b01, 2'd3);
    check("t5_gnt", gnt, 2'b01);
    check("t5_gnt_na", gnt_na, 2'b01);
    for (int c = 1; c <= 17; c++) begin
      step(1'b0, 2'b00, 4'h3, 2'b01, 2'd3);
      check($sformatf("t5_T+%0d nd", c), nd, (c == 17));
      check($sformatf("t5_T+%0d force_cnt", c), fc, (c == 17) ? 8'd1 : 8'd0);
      check($sformatf("t5_T+%0d nd_na", c), nd_na, (c == 2));
      if (c == 2) check("t5_na_pc", pc_na, 2'd3);
      if (c == 17) check("t5_pc,pd", {pc, pd}, {2'd3, 1'b1});
    end
    step(1'b0, 2'b00, 4'h3, 2'b01, 2'd3);
    check("t5_after nd,pc,busy", {nd, pc, bsy}, {1'b0, 2'd3, 1'b0});
    check("t5_na_force_cnt", fc_na, 8'd0);

    // Reset during HOLD discards the pending sample.
    step(1'b0, 2'b01, 4'h3, 2'b01, 2'd3);
    check("t6_gnt", gnt, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b00, 4'h3, 2'b01, 2'd3);
      check($sformatf("t6_hold%0d busy", i), bsy, 1'b1);
    end
    step(1'b1, 2'b00, 4'h3, 2'b01, 2'd3);
    check("t6_rst nd", nd, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 2'b00, 4'h3, 2'b01, 2'd3);
      check($sformatf("t6_post%0d nd", i), nd, 1'b0);
      if (i == 0)
        check("t6_post pc,pd,busy,fc", {pc, pd, bsy, fc}, {2'd0, 1'b0, 1'b0, 8'd0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
